msrv32_irq_arbiter: RTL and testbench
=====================================

// Module: msrv32_irq_arbiter
// PURPOSE
//  Collects the machine external, timer and software interrupt sources and synchronizes them.
//  Keeps them pending, masks them with mie/meie/mtie/msie and picks one by fixed priority.
//  Presents that single request, with its cause, to machine control over a req/ack handshake.
//  Sits between the interrupt sources/CSR file and msrv32 machine control. Drives meip/mtip/msip
//  back to the CSR file.
// PARAMETERS
//  SYNC_STAGES     2  flop stages on asynchronous e_irq_in (legal values 2..4)
//  HOLDOFF_CYCLES  2  idle cycles after mret_in before re-arbitration (0 = none)
// PORTS
//  clk_in          in   1  clock
//  reset_in        in   1  reset, asynchronous, active-high
//  e_irq_in        in   1  external interrupt, asynchronous level
//  t_irq_in        in   1  timer interrupt, clk_in-synchronous level
//  s_irq_in        in   1  software interrupt strobe, synchronous; rising edge sets pending
//  s_irq_clr_in    in   1  clears software pending (CSR write of msip=0)
//  mie_in          in   1  mstatus.MIE global enable
//  meie_in/mtie_in/msie_in in 1 each  per-source enables
//  irq_ack_in      in   1  machine control has taken the trap (1-cycle pulse)
//  mret_in         in   1  mret retired (1-cycle pulse)
//  irq_req_out     out  1  interrupt request to machine control
//  cause_out       out  4  cause of the requested interrupt: 11=MEI, 3=MSI, 7=MTI
//  meip_out/mtip_out/msip_out out 1 each  pending bits to CSR file
//  busy_out        out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, sync chain 0, msip pending 0, holdoff counter 0.
//    Reset mid-handshake aborts it immediately.
//  meip_out = last sync stage of e_irq_in (level, not sticky).
//  mtip_out = t_irq_in registered once (level).
//  msip_out is sticky: set on s_irq_in 0->1 (edge detect vs previous cycle); cleared by s_irq_clr_in.
//    Set and clear in the same cycle: set wins.
//  Eligibility: elig = mie_in & {meip&meie, msip&msie, mtip&mtie}. Priority MEI > MSI > MTI.
//  FSM states:
//   IDLE: if any elig, latch the highest-priority cause into cause_out, assert irq_req_out,
//     and go to REQ. All changes are registered, so they are visible the edge after elig is seen.
//   REQ: irq_req_out=1, and cause_out is held stable for as long as req is high.
//     - On irq_ack_in, go to SERVICE; req drops the following cycle.
//     - If the latched source is no longer eligible and there is no ack, withdraw: req=0, go to IDLE.
//       A newly eligible higher-priority source does not change cause_out; it is handled only
//       through withdraw/re-arbitrate.
//     - Ack and loss of eligibility in the same cycle: ack wins.
//   SERVICE: irq_req_out=0; wait for mret_in.
//     - With HOLDOFF_CYCLES>0, go to HOLDOFF and load counter=HOLDOFF_CYCLES-1.
//     - With HOLDOFF_CYCLES=0, go directly to IDLE.
//   HOLDOFF: decrement the counter each cycle; go to IDLE the cycle after it reads 0.
//  irq_ack_in outside REQ, and mret_in outside SERVICE, are ignored.
//  cause_out keeps its last value when not requesting; only its REQ value is meaningful.
//  Latency, source edge sampled at edge 0 -> irq_req_out high:
//    - e_irq_in: after SYNC_STAGES+1 edges.
//    - t_irq_in and s_irq_in: after 2 edges.
//  Pending bits keep updating in every state. A source still pending after HOLDOFF is re-requested.
// TESTING
//  T1 e_irq_in=1, mie=meie=1 -> meip_out=1 after 2 edges, irq_req_out=1 after 3, cause_out=11;
//     irq_ack_in -> req=0 the next cycle, busy_out=1.
//  T2 t_irq_in and s_irq_in rise in the same cycle, all enables 1 -> cause_out=3 (MSI);
//     ack, mret, s_irq_clr_in -> after 2 holdoff cycles req=1 with cause_out=7.
//  T3 in REQ with cause 7, drop mtie_in before ack -> req=0 the next cycle, FSM=IDLE, busy_out=0.
//  T4 s_irq_in and s_irq_clr_in together -> msip_out=1; then clr alone -> msip_out=0;
//     a held-high s_irq_in does not re-set msip.
//  T5 mie_in=0 with all sources pending -> no req; set mie_in=1 -> req=1 next edge with cause 11.
//  T6 assert reset_in in SERVICE and in HOLDOFF -> all outputs 0 asynchronously;
//     after release a pending t_irq is re-requested within 2 edges.

Source files
------------

// File: rtl/msrv32_irq_arbiter.sv
// Machine-level interrupt arbiter: synchronizes/pends MEI, MTI, MSI, picks one by fixed
// priority and hands it to machine control over a req/ack handshake with post-mret holdoff.
module msrv32_irq_arbiter #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned HOLDOFF_CYCLES = 2
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       e_irq_in,
   input  logic       t_irq_in,
   input  logic       s_irq_in,
   input  logic       s_irq_clr_in,
   input  logic       mie_in,
   input  logic       meie_in,
   input  logic       mtie_in,
   input  logic       msie_in,
   input  logic       irq_ack_in,
   input  logic       mret_in,
   output logic       irq_req_out,
   output logic [3:0] cause_out,
   output logic       meip_out,
   output logic       mtip_out,
   output logic       msip_out,
   output logic       busy_out
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE, HOLDOFF} state_t;

   localparam logic [3:0] CAUSE_MEI = 4'd11;
   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;

   localparam int unsigned CNT_W = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD =
      (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : {CNT_W{1'b0}};

   logic [SYNC_STAGES-1:0] e_sync;
   logic                   s_prev;
   state_t                 state, state_n;
   logic [3:0]             cause_n;
   logic                   req_n;
   logic [CNT_W-1:0]       hold_cnt, hold_cnt_n;
   logic                   elig_e, elig_s, elig_t, latched_elig;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         e_sync   <= '0;
         mtip_out <= 1'b0;
         s_prev   <= 1'b0;
         msip_out <= 1'b0;
      end else begin
         e_sync   <= {e_sync[SYNC_STAGES-2:0], e_irq_in};
         mtip_out <= t_irq_in;
         s_prev   <= s_irq_in;
         // rising edge of the strobe takes precedence over a simultaneous clear
         if (s_irq_in && !s_prev)
            msip_out <= 1'b1;
         else if (s_irq_clr_in)
            msip_out <= 1'b0;
      end
   end

   assign meip_out = e_sync[SYNC_STAGES-1];
   assign busy_out = (state != IDLE);

   assign elig_e = mie_in & meip_out & meie_in;
   assign elig_s = mie_in & msip_out & msie_in;
   assign elig_t = mie_in & mtip_out & mtie_in;

   always_comb begin
      case (cause_out)
         CAUSE_MEI: latched_elig = elig_e;
         CAUSE_MSI: latched_elig = elig_s;
         CAUSE_MTI: latched_elig = elig_t;
         default:   latched_elig = 1'b0;
      endcase
   end

   always_comb begin
      state_n    = state;
      cause_n    = cause_out;
      req_n      = irq_req_out;
      hold_cnt_n = hold_cnt;
      case (state)
         IDLE: begin
            req_n = 1'b0;
            if (elig_e || elig_s || elig_t) begin
               cause_n = elig_e ? CAUSE_MEI : (elig_s ? CAUSE_MSI : CAUSE_MTI);
               req_n   = 1'b1;
               state_n = REQ;
            end
         end
         REQ: begin
            if (irq_ack_in) begin
               req_n   = 1'b0;
               state_n = SERVICE;
            end else if (!latched_elig) begin
               req_n   = 1'b0;
               state_n = IDLE;
            end
         end
         SERVICE: begin
            req_n = 1'b0;
            if (mret_in) begin
               if (HOLDOFF_CYCLES == 0) begin
                  state_n = IDLE;
               end else begin
                  state_n    = HOLDOFF;
                  hold_cnt_n = HOLD_LOAD;
               end
            end
         end
         HOLDOFF: begin
            req_n = 1'b0;
            if (hold_cnt == '0)
               state_n = IDLE;
            else
               hold_cnt_n = hold_cnt - 1'b1;
         end
         default: begin
            req_n   = 1'b0;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state       <= IDLE;
         cause_out   <= '0;
         irq_req_out <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         state       <= state_n;
         cause_out   <= cause_n;
         irq_req_out <= req_n;
         hold_cnt    <= hold_cnt_n;
      end
   end

endmodule

// File: tb/tb_msrv32_irq_arbiter.sv
// Bench for msrv32_irq_arbiter: directed vector table, hand sequences for handshake/reset
// corners, and randomized stimulus against a behavioural model.
module tb_msrv32_irq_arbiter;

   localparam int unsigned SYNC_STAGES    = 2;
   localparam int unsigned HOLDOFF_CYCLES = 2;

   logic       clk_in = 1'b0;
   logic       reset_in;
   logic       e_irq_in, t_irq_in, s_irq_in, s_irq_clr_in;
   logic       mie_in, meie_in, mtie_in, msie_in;
   logic       irq_ack_in, mret_in;
   logic       irq_req_out;
   logic [3:0] cause_out;
   logic       meip_out, mtip_out, msip_out, busy_out;

   int n_tests = 0;
   int n_fail  = 0;

   msrv32_irq_arbiter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
   ) dut (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .e_irq_in    (e_irq_in),
      .t_irq_in    (t_irq_in),
      .s_irq_in    (s_irq_in),
      .s_irq_clr_in(s_irq_clr_in),
      .mie_in      (mie_in),
      .meie_in     (meie_in),
      .mtie_in     (mtie_in),
      .msie_in     (msie_in),
      .irq_ack_in  (irq_ack_in),
      .mret_in     (mret_in),
      .irq_req_out (irq_req_out),
      .cause_out   (cause_out),
      .meip_out    (meip_out),
      .mtip_out    (mtip_out),
      .msip_out    (msip_out),
      .busy_out    (busy_out)
   );

   always #5 clk_in = ~clk_in;

   // {req, cause[3:0], meip, mtip, msip, busy}
   function automatic logic [8:0] outs();
      return {irq_req_out, cause_out, meip_out, mtip_out, msip_out, busy_out};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // {e, t, s, clr, mie, meie, mtie, msie, ack, mret}
   task automatic apply_in(input logic [9:0] v);
      {e_irq_in, t_irq_in, s_irq_in, s_irq_clr_in, mie_in, meie_in,
       mtie_in, msie_in, irq_ack_in, mret_in} = v;
   endtask

   task automatic step();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   // ---------------- behavioural model ----------------
   bit         m_eq[$];
   bit         m_meip, m_mtip, m_msip, m_sprev;
   int         m_phase;  // 0 idle, 1 requesting, 2 in service, 3 holdoff
   int         m_left;
   logic [3:0] m_cause;

   task automatic model_reset();
      m_eq = {};
      for (int i = 0; i < int'(SYNC_STAGES); i++) m_eq.push_back(1'b0);
      m_meip = 0; m_mtip = 0; m_msip = 0; m_sprev = 0;
      m_phase = 0; m_left = 0; m_cause = 4'd0;
   endtask

   task automatic model_step();
      bit ee, es, et, still;
      ee = mie_in & m_meip & meie_in;
      es = mie_in & m_msip & msie_in;
      et = mie_in & m_mtip & mtie_in;
      case (m_phase)
         0: if (ee || es || et) begin
               m_cause = ee ? 4'd11 : (es ? 4'd3 : 4'd7);
               m_phase = 1;
            end
         1: begin
               still = (m_cause == 4'd11) ? ee : ((m_cause == 4'd3) ? es : et);
               if (irq_ack_in) m_phase = 2;
               else if (!still) m_phase = 0;
            end
         2: if (mret_in) begin
               if (HOLDOFF_CYCLES == 0) m_phase = 0;
               else begin m_phase = 3; m_left = int'(HOLDOFF_CYCLES); end
            end
         default: begin
               m_left--;
               if (m_left == 0) m_phase = 0;
            end
      endcase
      m_eq.push_back(e_irq_in);
      void'(m_eq.pop_front());
      m_meip = m_eq[0];
      m_mtip = t_irq_in;
      if (s_irq_in && !m_sprev) m_msip = 1;
      else if (s_irq_clr_in)    m_msip = 0;
      m_sprev = s_irq_in;
   endtask

   function automatic logic [8:0] model_outs();
      return {m_phase == 1, m_cause, m_meip, m_mtip, m_msip, m_phase != 0};
   endfunction

   task automatic do_reset();
      @(negedge clk_in);
      apply_in(10'b0);
      reset_in = 1'b1;
      #1 check("reset outs", 32'(outs()), 32'h0);
      @(negedge clk_in);
      @(negedge clk_in);
      reset_in = 1'b0;
      model_reset();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [9:0] in;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[26];

   initial begin
      //          e t s c M E T S a r            q cause p t s b
      vecs[0]  = '{10'b1_0_0_0_1_1_0_0_0_0, 9'b0_0000_0_0_0_0};
      vecs[1]  = '{10'b1_0_0_0_1_1_0_0_0_0, 9'b0_0000_1_0_0_0};
      vecs[2]  = '{10'b1_0_0_0_1_1_0_0_0_0, 9'b1_1011_1_0_0_1};
      vecs[3]  = '{10'b1_0_0_0_1_1_0_0_1_0, 9'b0_1011_1_0_0_1};
      vecs[4]  = '{10'b0_0_0_0_1_1_0_0_0_1, 9'b0_1011_1_0_0_1};
      vecs[5]  = '{10'b0_0_0_0_1_1_0_0_0_0, 9'b0_1011_0_0_0_1};
      vecs[6]  = '{10'b0_0_0_0_1_1_0_0_0_0, 9'b0_1011_0_0_0_0};
      vecs[7]  = '{10'b0_0_0_0_1_1_0_0_0_0, 9'b0_1011_0_0_0_0};
      vecs[8]  = '{10'b0_0_1_1_1_1_0_0_0_0, 9'b0_1011_0_0_1_0};
      vecs[9]  = '{10'b0_0_1_1_1_1_0_0_0_0, 9'b0_1011_0_0_0_0};
      vecs[10] = '{10'b0_0_1_0_1_1_0_0_0_0, 9'b0_1011_0_0_0_0};
      vecs[11] = '{10'b0_0_0_0_1_1_0_0_0_0, 9'b0_1011_0_0_0_0};
      vecs[12] = '{10'b0_0_1_0_1_1_0_0_0_0, 9'b0_1011_0_0_1_0};
      vecs[13] = '{10'b0_0_0_1_1_1_0_0_0_0, 9'b0_1011_0_0_0_0};
      vecs[14] = '{10'b1_1_1_0_0_1_1_1_0_0, 9'b0_1011_0_1_1_0};
      vecs[15] = '{10'b1_1_0_0_0_1_1_1_0_0, 9'b0_1011_1_1_1_0};
      vecs[16] = '{10'b1_1_0_0_0_1_1_1_0_0, 9'b0_1011_1_1_1_0};
      vecs[17] = '{10'b1_1_0_0_1_1_1_1_0_0, 9'b1_1011_1_1_1_1};
      vecs[18] = '{10'b1_1_0_0_1_1_1_1_1_0, 9'b0_1011_1_1_1_1};
      vecs[19] = '{10'b1_1_0_0_1_1_1_1_0_1, 9'b0_1011_1_1_1_1};
      vecs[20] = '{10'b1_1_0_0_1_1_1_1_0_0, 9'b0_1011_1_1_1_1};
      vecs[21] = '{10'b1_1_0_0_1_1_1_1_0_0, 9'b0_1011_1_1_1_0};
      vecs[22] = '{10'b1_1_0_0_1_1_1_1_0_0, 9'b1_1011_1_1_1_1};
      vecs[23] = '{10'b0_0_0_1_1_1_1_1_0_0, 9'b1_1011_1_0_0_1};
      vecs[24] = '{10'b0_0_0_0_1_1_1_1_0_0, 9'b1_1011_0_0_0_1};
      vecs[25] = '{10'b0_0_0_0_1_1_1_1_0_0, 9'b0_1011_0_0_0_0};

      apply_in(10'b0);
      reset_in = 1'b1;
      #1 check("async reset", 32'(outs()), 32'h0);
      do_reset();

      for (int i = 0; i < 26; i++) begin
         apply_in(vecs[i].in);
         step();
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      end

      // T2: simultaneous MTI/MSI -> MSI first; MTI re-requested after holdoff
      do_reset();
      apply_in(10'b0_1_1_0_1_1_1_1_0_0);
      step();
      check("T2 pend", 32'(outs()), 32'(9'b0_0000_0_1_1_0));
      s_irq_in = 1'b0;
      step();
      check("T2 req", {31'd0, irq_req_out}, 32'd1);
      check("T2 cause", 32'(cause_out), 32'd3);
      irq_ack_in = 1'b1; step(); irq_ack_in = 1'b0;
      check("T2 ack", {31'd0, irq_req_out}, 32'd0);
      mret_in = 1'b1; s_irq_clr_in = 1'b1; step(); mret_in = 1'b0; s_irq_clr_in = 1'b0;
      step();
      step();
      check("T2 holdoff", 32'({irq_req_out, msip_out}), 32'd0);
      step();
      check("T2 rereq", 32'({irq_req_out, cause_out}), 32'({1'b1, 4'd7}));

      // T3: withdraw on loss of eligibility
      mtie_in = 1'b0;
      step();
      check("T3 withdraw", 32'({irq_req_out, busy_out}), 32'd0);
      mtie_in = 1'b1;
      step();
      check("T3 again", 32'({irq_req_out, cause_out}), 32'({1'b1, 4'd7}));

      // T6: async reset in SERVICE and HOLDOFF
      irq_ack_in = 1'b1; step(); irq_ack_in = 1'b0;
      check("T6 svc busy", 32'({irq_req_out, busy_out}), 32'd1);
      #2 reset_in = 1'b1;
      #1 check("T6 reset svc", 32'(outs()), 32'h0);
      @(negedge clk_in); reset_in = 1'b0;
      step(); step();
      check("T6 rereq1", 32'({irq_req_out, cause_out}), 32'({1'b1, 4'd7}));
      irq_ack_in = 1'b1; step(); irq_ack_in = 1'b0;
      mret_in = 1'b1; step(); mret_in = 1'b0;
      check("T6 hold busy", 32'({irq_req_out, busy_out}), 32'd1);
      #2 reset_in = 1'b1;
      #1 check("T6 reset hold", 32'(outs()), 32'h0);
      @(negedge clk_in); reset_in = 1'b0;
      step(); step();
      check("T6 rereq2", 32'({irq_req_out, cause_out}), 32'({1'b1, 4'd7}));

      // randomized run against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) e_irq_in = ~e_irq_in;
         if ($urandom_range(0, 7) == 0)  t_irq_in = ~t_irq_in;
         if ($urandom_range(0, 3) == 0)  s_irq_in = ~s_irq_in;
         s_irq_clr_in = ($urandom_range(0, 7) == 0);
         mie_in       = ($urandom_range(0, 7) != 0);
         meie_in      = ($urandom_range(0, 5) != 0);
         mtie_in      = ($urandom_range(0, 5) != 0);
         msie_in      = ($urandom_range(0, 5) != 0);
         irq_ack_in   = ($urandom_range(0, 2) == 0);
         mret_in      = ($urandom_range(0, 2) == 0);
         @(posedge clk_in);
         model_step();
         @(negedge clk_in);
         check($sformatf("rand%0d", c), 32'(outs()), 32'(model_outs()));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
